// File: rtl/ssd_scan_arb_pkg.sv
// rtl/ssd_scan_arb_pkg.sv - shared constants, FSM encoding and digit-enable helper for the display scanner
package ssd_scan_arb_pkg;

   localparam int SSD_NUM       = 4;
   localparam int SSD_BIT_WIDTH = 4;
   localparam int IDX_W         = $clog2(SSD_NUM);

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } scan_state_e;

   localparam logic [SSD_NUM-1:0] SSD_OFF = 4'b1111;
   localparam logic [SSD_NUM-1:0] SSD_EN0 = 4'b1110;
   localparam logic [SSD_NUM-1:0] SSD_EN1 = 4'b1101;
   localparam logic [SSD_NUM-1:0] SSD_EN2 = 4'b1011;
   localparam logic [SSD_NUM-1:0] SSD_EN3 = 4'b0111;

   function automatic logic [SSD_NUM-1:0] digit_en(input logic [IDX_W-1:0] idx);
      case (idx)
         2'd0:    return SSD_EN0;
         2'd1:    return SSD_EN1;
         2'd2:    return SSD_EN2;
         default: return SSD_EN3;
      endcase
   endfunction

endpackage

// File: rtl/ssd_scan_arb_scan_timer.sv
// rtl/ssd_scan_arb_scan_timer.sv - BLANK/SHOW phase FSM with digit index and phase counter
// Outputs describe the cycle that the next clock edge enters, so the top can register them without lag.
module scan_timer
   import ssd_scan_arb_pkg::*;
#(
   parameter int SCAN_DIV  = 25000,
   parameter int BLANK_CYC = 500
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [IDX_W-1:0] idx,
   output logic             show,
   output logic             frame_end
);

   localparam int PMAX   = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
   localparam int PCNT_W = (PMAX > 1) ? $clog2(PMAX) : 1;

   scan_state_e       state, state_n;
   logic [IDX_W-1:0]  idx_q, idx_n;
   logic [PCNT_W-1:0] pcnt, pcnt_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= BLANK;
         idx_q <= '0;
         pcnt  <= '0;
      end else begin
         state <= state_n;
         idx_q <= idx_n;
         pcnt  <= pcnt_n;
      end
   end

   always_comb begin
      state_n = state;
      idx_n   = idx_q;
      pcnt_n  = pcnt + PCNT_W'(1);
      case (state)
         BLANK: begin
            if (pcnt == PCNT_W'(BLANK_CYC - 1)) begin
               state_n = SHOW;
               pcnt_n  = '0;
            end
         end
         default: begin
            if (pcnt == PCNT_W'(SCAN_DIV - 1)) begin
               state_n = BLANK;
               pcnt_n  = '0;
               idx_n   = idx_q + IDX_W'(1);
            end
         end
      endcase
   end

   // The frame boundary is the final SHOW cycle of the last digit.
   always_comb begin
      idx       = idx_n;
      show      = (state_n == SHOW);
      frame_end = (state_n == SHOW) && (idx_n == IDX_W'(SSD_NUM - 1))
                  && (pcnt_n == PCNT_W'(SCAN_DIV - 1));
   end

endmodule

// File: rtl/ssd_scan_arb.sv
// rtl/ssd_scan_arb.sv - 7-segment scan scheduler with frame-aligned A/B source arbitration
module ssd_scan_arb
   import ssd_scan_arb_pkg::*;
#(
   parameter int SCAN_DIV  = 25000,
   parameter int BLANK_CYC = 500
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [SSD_BIT_WIDTH-1:0] a_d0,
   input  logic [SSD_BIT_WIDTH-1:0] a_d1,
   input  logic [SSD_BIT_WIDTH-1:0] a_d2,
   input  logic [SSD_BIT_WIDTH-1:0] a_d3,
   input  logic [SSD_BIT_WIDTH-1:0] b_d0,
   input  logic [SSD_BIT_WIDTH-1:0] b_d1,
   input  logic [SSD_BIT_WIDTH-1:0] b_d2,
   input  logic [SSD_BIT_WIDTH-1:0] b_d3,
   input  logic                     req_b,
   output logic                     gnt_b,
   output logic [SSD_NUM-1:0]       ssd_ctl,
   output logic [SSD_BIT_WIDTH-1:0] ssd_in,
   output logic                     frame_tick
);

   logic [IDX_W-1:0]         idx;
   logic                     show;
   logic                     frame_end;
   logic [SSD_BIT_WIDTH-1:0] digit;

   scan_timer #(
      .SCAN_DIV  (SCAN_DIV),
      .BLANK_CYC (BLANK_CYC)
   ) u_scan_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .idx       (idx),
      .show      (show),
      .frame_end (frame_end)
   );

   always_comb begin
      digit = '0;
      case (idx)
         2'd0:    digit = gnt_b ? b_d0 : a_d0;
         2'd1:    digit = gnt_b ? b_d1 : a_d1;
         2'd2:    digit = gnt_b ? b_d2 : a_d2;
         default: digit = gnt_b ? b_d3 : a_d3;
      endcase
   end

   // frame_tick is high during the boundary cycle, so req_b is sampled exactly there.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ssd_ctl    <= SSD_OFF;
         ssd_in     <= '0;
         gnt_b      <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         ssd_ctl    <= show ? digit_en(idx) : SSD_OFF;
         ssd_in     <= show ? digit : '0;
         frame_tick <= frame_end;
         if (frame_tick)
            gnt_b <= req_b;
      end
   end

endmodule

// File: tb/tb_ssd_scan_arb.sv
// tb/tb_ssd_scan_arb.sv - scoreboard bench for ssd_scan_arb with SCAN_DIV=4, BLANK_CYC=2
module tb_ssd_scan_arb;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_b = 1'b0;
   logic [3:0] a_d0 = 4'd1, a_d1 = 4'd2, a_d2 = 4'd3, a_d3 = 4'd4;
   logic [3:0] b_d0 = 4'd9, b_d1 = 4'd8, b_d2 = 4'd7, b_d3 = 4'd6;
   logic       gnt_b;
   logic [3:0] ssd_ctl;
   logic [3:0] ssd_in;
   logic       frame_tick;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [9:0] sb[$];
   logic [9:0] exp_v;
   logic [9:0] obs_v;

   ssd_scan_arb #(
      .SCAN_DIV  (4),
      .BLANK_CYC (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .a_d0       (a_d0),
      .a_d1       (a_d1),
      .a_d2       (a_d2),
      .a_d3       (a_d3),
      .b_d0       (b_d0),
      .b_d1       (b_d1),
      .b_d2       (b_d2),
      .b_d3       (b_d3),
      .req_b      (req_b),
      .gnt_b      (gnt_b),
      .ssd_ctl    (ssd_ctl),
      .ssd_in     (ssd_in),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   // One frame: per digit 2 blank cycles then 4 lit cycles; tick on the very last lit cycle.
   task automatic push_frame(input bit use_b, input bit g);
      logic [3:0] vals[4];
      logic [3:0] en;
      if (use_b) vals = '{4'd9, 4'd8, 4'd7, 4'd6};
      else       vals = '{4'd1, 4'd2, 4'd3, 4'd4};
      for (int d = 0; d < 4; d++) begin
         for (int c = 0; c < 2; c++) sb.push_back({4'b1111, 4'h0, g, 1'b0});
         en = ~(4'b0001 << d);
         for (int c = 0; c < 4; c++)
            sb.push_back({en, vals[d], g, (d == 3 && c == 3) ? 1'b1 : 1'b0});
      end
   endtask

   task automatic check_n(input int n);
      for (int i = 0; i < n; i++) begin
         n_cmp++;
         obs_v = {ssd_ctl, ssd_in, gnt_b, frame_tick};
         if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL sb_empty observed ctl/in/gnt/tick=%b expected an entry", obs_v);
         end else begin
            exp_v = sb.pop_front();
            assert (obs_v === exp_v) else begin
               n_fail++;
               $error("FAIL scan t=%0t observed ctl=%b in=%h gnt=%b tick=%b expected ctl=%b in=%h gnt=%b tick=%b",
                      $time, obs_v[9:6], obs_v[5:2], obs_v[1], obs_v[0],
                      exp_v[9:6], exp_v[5:2], exp_v[1], exp_v[0]);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      n_cmp++;
      obs_v = {ssd_ctl, ssd_in, gnt_b, frame_tick};
      exp_v = {4'b1111, 4'h0, 1'b0, 1'b0};
      assert (obs_v === exp_v) else begin
         n_fail++;
         $error("FAIL %s observed ctl/in/gnt/tick=%b expected %b", tag, obs_v, exp_v);
      end
   endtask

   initial begin
      // Reset values while held
      repeat (3) @(negedge clk);
      check_reset_vals("reset_hold");

      // Reset release, then a full A frame
      push_frame(1'b0, 1'b0);
      rst_n = 1'b1;
      check_n(24);

      // Grant requested mid digit 1: current frame stays A
      push_frame(1'b0, 1'b0);
      check_n(9);
      req_b = 1'b1;
      check_n(15);

      // B frame; req_b dropped during digit 2
      push_frame(1'b1, 1'b1);
      check_n(15);
      req_b = 1'b0;
      check_n(9);

      // A frame; req_b high only on the frame_tick cycle
      push_frame(1'b0, 1'b0);
      check_n(23);
      req_b = 1'b1;
      check_n(1);
      req_b = 1'b0;

      // Granted B frame from the boundary-only request
      push_frame(1'b1, 1'b1);
      check_n(24);

      // A frame with a short pulse inside digit 1
      push_frame(1'b0, 1'b0);
      check_n(8);
      req_b = 1'b1;
      check_n(3);
      req_b = 1'b0;
      check_n(13);

      // Pulse ignored: A again; request held for the next frame
      push_frame(1'b0, 1'b0);
      req_b = 1'b1;
      check_n(24);

      // B frame, reset during digit 2
      push_frame(1'b1, 1'b1);
      check_n(15);
      rst_n = 1'b0;
      #1;
      check_reset_vals("reset_async");
      sb.delete();
      req_b = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_vals("reset_mid_hold");

      push_frame(1'b0, 1'b0);
      rst_n = 1'b1;
      check_n(24);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed no finish expected finish before 100000");
      $fatal(1, "timeout");
   end

endmodule
